// File: rtl/mux_stream.sv
// mux_stream: round-robin N:1 stream multiplexer with a single registered
// output stage. One word per cycle throughput when downstream keeps
// out_ready high.
//
// Optional feature: define MUX_STREAM_FORCE_EN to add force_en/force_sel,
// which pin the grant to one channel without disturbing the round-robin
// pointer.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | output register holds no unconsumed word (out_valid=0)
// FULL  | output register holds a word awaiting out_ready  (out_valid=1)

module mux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef MUX_STREAM_FORCE_EN
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
`endif
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_found;
    logic               forcing;
    logic               can_load;
    logic               in_xfer;
    logic [WIDTH-1:0]   sel_data;

    assign out_valid = (state == FULL);
    assign can_load  = !out_valid || out_ready;

    // Pick the granted channel: forced channel if enabled, otherwise the first
    // valid channel after ptr, wrapping around.
    always_comb begin
        int unsigned c;
        logic [SEL_W-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = ptr;
        forcing     = 1'b0;
        c           = 0;
        idx         = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            c = int'(ptr) + k;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            idx = SEL_W'(c);
            if (!grant_found && in_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
`ifdef MUX_STREAM_FORCE_EN
        if (force_en) begin
            forcing     = 1'b1;
            grant_found = 1'b0;
            grant_idx   = ptr;
            if ({1'b0, force_sel} < (SEL_W+1)'(CHANNELS)) begin
                if (in_valid[force_sel]) begin
                    grant_found = 1'b1;
                    grant_idx   = force_sel;
                end
            end
        end
`endif
    end

    // Route the granted channel's word; other channels' data is never looked at.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Single accept strobe, suppressed during reset and while the output is stalled.
    always_comb begin
        in_ready = '0;
        if (!rst && can_load && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer = |(in_valid & in_ready);

    // Output stage FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_chan <= '0;
            ptr      <= SEL_W'(CHANNELS - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state    <= FULL;
                        out_data <= sel_data;
                        out_chan <= grant_idx;
                    end
                end
                FULL: begin
                    if (in_xfer) begin
                        out_data <= sel_data;
                        out_chan <= grant_idx;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (in_xfer && !forcing) begin
                ptr <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream.sv
// tb_mux_stream: directed, table-driven bench for mux_stream (WIDTH=8,
// CHANNELS=8). Build with MUX_STREAM_FORCE_EN defined to also exercise the
// forced-grant ports.

module tb_mux_stream;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SEL_W-1:0]          out_chan;
`ifdef MUX_STREAM_FORCE_EN
    logic                      force_en;
    logic [SEL_W-1:0]          force_sel;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_stream #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_STREAM_FORCE_EN
        .force_en  (force_en),
        .force_sel (force_sel),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    typedef struct {
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] oc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] iv, input logic ordy, input logic [7:0] rdy,
                       input logic ov, input logic [7:0] od, input logic [2:0] oc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.od = od; v.oc = oc;
        vecs.push_back(v);
    endtask

    // Called right after a posedge (+1); drives inputs, checks in_ready at the
    // negedge and the registered outputs just after the next posedge.
    task automatic cycle(input string name, input logic [7:0] iv, input logic ordy,
                         input logic [7:0] rdy, input logic ov, input logic [7:0] od,
                         input logic [2:0] oc);
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clk);
        chk({name, " in_ready"}, 64'(in_ready), 64'(rdy));
        @(posedge clk);
        #1;
        chk({name, " out_valid"}, 64'(out_valid), 64'(ov));
        chk({name, " out_data"},  64'(out_data),  64'(od));
        chk({name, " out_chan"},  64'(out_chan),  64'(oc));
    endtask

    initial begin
        logic [7:0] ch_word [CHANNELS];
        ch_word = '{8'h00, 8'hFF, 8'hAA, 8'h55, 8'hCC, 8'h33, 8'hE0, 8'h0F};
        for (int i = 0; i < CHANNELS; i++) begin
            in_data[i*WIDTH +: WIDTH] = ch_word[i];
        end
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef MUX_STREAM_FORCE_EN
        force_en  = 1'b0;
        force_sel = '0;
`endif

        // iv, out_ready, in_ready, out_valid, out_data, out_chan
        add(8'h01, 1'b1, 8'h01, 1'b1, 8'h00, 3'd0);   // first word after reset
        add(8'hFF, 1'b1, 8'h02, 1'b1, 8'hFF, 3'd1);   // full round-robin sweep
        add(8'hFF, 1'b1, 8'h04, 1'b1, 8'hAA, 3'd2);
        add(8'hFF, 1'b1, 8'h08, 1'b1, 8'h55, 3'd3);
        add(8'hFF, 1'b1, 8'h10, 1'b1, 8'hCC, 3'd4);
        add(8'hFF, 1'b1, 8'h20, 1'b1, 8'h33, 3'd5);
        add(8'hFF, 1'b1, 8'h40, 1'b1, 8'hE0, 3'd6);
        add(8'hFF, 1'b1, 8'h80, 1'b1, 8'h0F, 3'd7);
        add(8'hFF, 1'b1, 8'h01, 1'b1, 8'h00, 3'd0);   // wrap to channel 0
        add(8'h04, 1'b1, 8'h04, 1'b1, 8'hAA, 3'd2);   // FULL with 0xAA
        add(8'h08, 1'b0, 8'h00, 1'b1, 8'hAA, 3'd2);   // stalled 3 cycles
        add(8'h08, 1'b0, 8'h00, 1'b1, 8'hAA, 3'd2);
        add(8'h08, 1'b0, 8'h00, 1'b1, 8'hAA, 3'd2);
        add(8'h08, 1'b1, 8'h08, 1'b1, 8'h55, 3'd3);   // release -> channel 3
        add(8'h00, 1'b1, 8'h00, 1'b0, 8'h55, 3'd3);   // drain, data retained
        add(8'h00, 1'b0, 8'h00, 1'b0, 8'h55, 3'd3);   // idle, ptr holds at 3
        add(8'hA0, 1'b0, 8'h20, 1'b1, 8'h33, 3'd5);   // EMPTY loads even without out_ready
        add(8'hA0, 1'b0, 8'h00, 1'b1, 8'h33, 3'd5);
        add(8'hA0, 1'b1, 8'h80, 1'b1, 8'h0F, 3'd7);
        add(8'hA0, 1'b1, 8'h20, 1'b1, 8'h33, 3'd5);
        add(8'h21, 1'b1, 8'h01, 1'b1, 8'h00, 3'd0);   // search wraps past 7
        add(8'h02, 1'b0, 8'h00, 1'b1, 8'h00, 3'd0);   // valid drops without handshake
        add(8'h04, 1'b1, 8'h04, 1'b1, 8'hAA, 3'd2);

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data",  64'(out_data),  64'd0);
        chk("reset out_chan",  64'(out_chan),  64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle($sformatf("v%0d", i), vecs[i].iv, vecs[i].ordy, vecs[i].rdy,
                  vecs[i].ov, vecs[i].od, vecs[i].oc);
        end

        // mid-operation reset discards the FULL word and blocks acceptance
        rst = 1'b1;
        cycle("rst_pulse", 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0);
        rst = 1'b0;
        cycle("post_rst_idle", 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0);
        cycle("post_rst_grant", 8'h0C, 1'b1, 8'h04, 1'b1, 8'hAA, 3'd2);

`ifdef MUX_STREAM_FORCE_EN
        force_en  = 1'b1;
        force_sel = 3'd5;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("force%0d", i), 8'hFF, 1'b1, 8'h20, 1'b1, 8'h33, 3'd5);
        end
        force_en = 1'b0;
        cycle("force_release", 8'hFF, 1'b1, 8'h08, 1'b1, 8'h55, 3'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_stream.md
MUX_STREAM -- requirements
Module: mux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 8, input channel count (2..16).
REQ-003 SHALL derive localparam SEL_W = $clog2(CHANNELS), width of channel indices.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel word-present flag.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel accept strobe.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  downstream accept.
REQ-012 SHALL have port out_chan  output  SEL_W  source channel index of out_data.

Function
REQ-013 SHALL treat a transfer on channel i as in_valid[i] && in_ready[i] in the same cycle; output transfer as out_valid && out_ready.
REQ-014 SHALL operate as a two-state output stage: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL define "can_load" = !out_valid || out_ready (combinational).
REQ-016 SHALL assert at most one in_ready bit per cycle: bit g, where g is the granted channel, and only when can_load and in_valid[g].
REQ-017 SHALL grant round-robin: g = first channel with in_valid set, searching from (ptr+1) mod CHANNELS upward with wrap-around.
REQ-018 SHALL update ptr to g only on a cycle with an input transfer; otherwise ptr holds.
REQ-019 SHALL, on an input transfer, load out_data <= channel g word, out_chan <= g, out_valid <= 1 on the next edge (latency 1 cycle).
REQ-020 SHALL, on an output transfer with no input transfer, clear out_valid next edge (FULL->EMPTY); out_data and out_chan retain their last values.
REQ-021 SHALL, on simultaneous output and input transfer, stay FULL and replace the word, sustaining one word per cycle.
REQ-022 SHALL, while FULL and out_ready=0, hold out_data/out_chan stable and drive in_ready all zero.
REQ-023 SHALL, with in_valid all zero, drive in_ready all zero and leave ptr unchanged.
REQ-024 SHALL not depend on in_data of non-granted channels; in_valid may fall without handshake without corrupting state.

Reset
REQ-025 SHALL on rst=1 at a clock edge set out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (channel 0 highest priority first).
REQ-026 SHALL drive in_ready all zero during any cycle where rst=1.
REQ-027 SHALL discard a held FULL word when reset asserts mid-operation; no word is emitted after reset release until a new input transfer.

Configuration
REQ-028 SHALL support macro MUX_STREAM_FORCE_EN adding ports force_en (input 1) and force_sel (input SEL_W).
REQ-029 With MUX_STREAM_FORCE_EN defined and force_en=1, SHALL grant only channel force_sel (other in_ready bits 0) and leave ptr unchanged; force_sel >= CHANNELS grants nothing.
REQ-030 Without MUX_STREAM_FORCE_EN, SHALL have no force ports and always use round-robin.

Verification (WIDTH=8, CHANNELS=8)
REQ-031 Reset then in_valid=0x01, ch0=0x00, out_ready=1 -> next cycle out_valid=1, out_data=0x00, out_chan=0.
REQ-032 in_valid=0xFF held, ch0..7 = 00,FF,AA,55,CC,33,E0,0F, out_ready=1 -> out_chan sequence 0..7 then 0 (wrap), one word per cycle, data matching.
REQ-033 FULL with 0xAA, out_ready=0 for 3 cycles, in_valid=0x08 -> in_ready=0, out_data stays 0xAA; out_ready=1 -> next cycle out_data=0x55, out_chan=3.
REQ-034 FULL word present, rst pulsed 1 cycle -> out_valid=0, out_data=0x00, out_chan=0; first post-reset grant goes to lowest valid channel.
REQ-035 With MUX_STREAM_FORCE_EN: in_valid=0xFF, force_en=1, force_sel=5 -> only in_ready[5] asserts, out_data=0x33 every cycle; force_en=0 -> round-robin resumes from pointer held before forcing.
